// File: rtl/eth_frame_gen_if.sv
// Control, buffer-write and GMII transmit signals of the frame generator.
// The master drives buffer writes and run control; the slave (generator) drives GMII.
interface eth_frame_gen_if #(
    parameter int unsigned ADDR_W = 11
) ();
    logic              wr_en_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [7:0]        wr_data_in;
    logic              start_in;
    logic              stop_in;
    logic [ADDR_W:0]   len_in;
    logic [15:0]       count_in;
    logic [1:0]        mode_in;
    logic              pad_en_in;
    logic [ADDR_W-1:0] err_idx_in;
    logic [7:0]        tx_d_out;
    logic              tx_en_out;
    logic              tx_err_out;
    logic              busy_out;
    logic              done_out;
    logic [15:0]       frames_sent_out;

    modport master (
        output wr_en_in, wr_addr_in, wr_data_in, start_in, stop_in,
               len_in, count_in, mode_in, pad_en_in, err_idx_in,
        input  tx_d_out, tx_en_out, tx_err_out, busy_out, done_out, frames_sent_out
    );

    modport slave (
        input  wr_en_in, wr_addr_in, wr_data_in, start_in, stop_in,
               len_in, count_in, mode_in, pad_en_in, err_idx_in,
        output tx_d_out, tx_en_out, tx_err_out, busy_out, done_out, frames_sent_out
    );
endinterface

// File: rtl/eth_frame_gen.sv
// GMII frame generator: plays a buffered frame with preamble/SFD, optional padding,
// appended FCS and inter-frame gap, for N frames or continuously, with error injection.
module eth_frame_gen #(
    parameter int unsigned MEM_DEPTH = 2048,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned PRE_BYTES = 7,
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MIN_LEN   = 60
) (
    input  logic           clk,
    input  logic           rst,
    eth_frame_gen_if.slave bus
);
    localparam int unsigned LEN_W    = ADDR_W + 1;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [1:0]  MODE_RAW = 2'b01;
    localparam logic [1:0]  MODE_BAD = 2'b10;
    localparam logic [1:0]  MODE_SYM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    logic [7:0]        r_mem [MEM_DEPTH];
    logic [7:0]        r_rd_q;
    logic [ADDR_W-1:0] w_rd_addr;

    state_t            r_state, w_state_nx;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nx;
    logic [LEN_W-1:0]  r_len;
    logic [15:0]       r_count;
    logic [1:0]        r_mode;
    logic              r_pad_en;
    logic [ADDR_W-1:0] r_err_idx;
    logic              r_stop_pend;
    logic [31:0]       r_crc, w_crc_nx;
    logic [31:0]       w_fcs;

    logic [7:0]        r_tx_d, w_tx_d_nx;
    logic              r_tx_en, w_tx_en_nx;
    logic              r_tx_err, w_tx_err_nx;
    logic              r_busy, r_done;
    logic [15:0]       r_frames;

    logic              w_start_ok, w_pad_applies, w_count_hit, w_stop_now, w_frame_done;
    logic [LEN_W-1:0]  w_len_clamp;

    // Byte buffer: simple dual-port, one-cycle read latency, not reset
    always_ff @(posedge clk) begin
        if (bus.wr_en_in) begin
            r_mem[bus.wr_addr_in] <= bus.wr_data_in;
        end
        r_rd_q <= r_mem[w_rd_addr];
    end

    // Address runs two bytes ahead of the output: RAM latency plus output register
    always_comb begin
        w_rd_addr = '0;
        if (r_state == S_SFD) begin
            w_rd_addr = ADDR_W'(1);
        end else if (r_state == S_DATA) begin
            w_rd_addr = ADDR_W'(r_cnt + LEN_W'(2));
        end
    end

    assign w_start_ok    = (r_state == S_IDLE) && bus.start_in && (bus.len_in != '0);
    assign w_len_clamp   = (bus.len_in > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : bus.len_in;
    assign w_pad_applies = r_pad_en && (r_mode != MODE_RAW) && (r_len < LEN_W'(MIN_LEN));
    assign w_count_hit   = (r_count != 16'd0) && (r_frames >= r_count);
    assign w_stop_now    = r_stop_pend || bus.stop_in;
    assign w_fcs         = ~r_crc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next state plus the output byte that goes with it
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + LEN_W'(1);
        w_frame_done = 1'b0;
        w_tx_d_nx    = 8'h00;
        w_tx_en_nx   = 1'b0;
        w_tx_err_nx  = 1'b0;
        w_crc_nx     = r_crc;

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_start_ok) w_state_nx = S_PRE;
            end
            S_PRE: begin
                if (r_cnt == LEN_W'(PRE_BYTES - 1)) begin
                    w_state_nx = S_SFD;
                    w_cnt_nx   = '0;
                end
            end
            S_SFD: begin
                w_state_nx = S_DATA;
                w_cnt_nx   = '0;
            end
            S_DATA: begin
                if (r_cnt == r_len - LEN_W'(1)) begin
                    if (r_mode == MODE_RAW) begin
                        w_state_nx   = S_IFG;
                        w_cnt_nx     = '0;
                        w_frame_done = 1'b1;
                    end else if (w_pad_applies) begin
                        w_state_nx = S_PAD;
                    end else begin
                        w_state_nx = S_FCS;
                        w_cnt_nx   = '0;
                    end
                end
            end
            S_PAD: begin
                // Counter carries on from len so padding ends at MIN_LEN
                if (r_cnt == LEN_W'(MIN_LEN - 1)) begin
                    w_state_nx = S_FCS;
                    w_cnt_nx   = '0;
                end
            end
            S_FCS: begin
                if (r_cnt == LEN_W'(3)) begin
                    w_state_nx   = S_IFG;
                    w_cnt_nx     = '0;
                    w_frame_done = 1'b1;
                end
            end
            S_IFG: begin
                if (r_cnt == LEN_W'(IFG_BYTES - 1)) begin
                    w_state_nx = (w_stop_now || w_count_hit) ? S_IDLE : S_PRE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        case (w_state_nx)
            S_PRE: begin
                w_tx_d_nx  = 8'h55;
                w_tx_en_nx = 1'b1;
            end
            S_SFD: begin
                w_tx_d_nx  = 8'hD5;
                w_tx_en_nx = 1'b1;
                w_crc_nx   = 32'hFFFF_FFFF;
            end
            S_DATA: begin
                w_tx_d_nx   = r_rd_q;
                w_tx_en_nx  = 1'b1;
                w_tx_err_nx = (r_mode == MODE_SYM) && (w_cnt_nx == {1'b0, r_err_idx});
                w_crc_nx    = crc_byte(r_crc, r_rd_q);
            end
            S_PAD: begin
                w_tx_en_nx = 1'b1;
                w_crc_nx   = crc_byte(r_crc, 8'h00);
            end
            S_FCS: begin
                w_tx_d_nx  = w_fcs[{w_cnt_nx[1:0], 3'b000} +: 8];
                w_tx_en_nx = 1'b1;
                if ((r_mode == MODE_BAD) && (w_cnt_nx[1:0] == 2'd3)) begin
                    w_tx_d_nx = w_tx_d_nx ^ 8'h01;
                end
            end
            default: ;
        endcase
    end

    // Run parameters, CRC, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len       <= '0;
            r_count     <= 16'd0;
            r_mode      <= 2'b00;
            r_pad_en    <= 1'b0;
            r_err_idx   <= '0;
            r_stop_pend <= 1'b0;
            r_crc       <= 32'hFFFF_FFFF;
            r_tx_d      <= 8'h00;
            r_tx_en     <= 1'b0;
            r_tx_err    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frames    <= 16'd0;
        end else begin
            r_crc    <= w_crc_nx;
            r_tx_d   <= w_tx_d_nx;
            r_tx_en  <= w_tx_en_nx;
            r_tx_err <= w_tx_err_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_done   <= (r_state == S_IFG) && (w_state_nx == S_IDLE);
            if (w_start_ok) begin
                r_len       <= w_len_clamp;
                r_count     <= bus.count_in;
                r_mode      <= bus.mode_in;
                r_pad_en    <= bus.pad_en_in;
                r_err_idx   <= bus.err_idx_in;
                r_stop_pend <= 1'b0;
                r_frames    <= 16'd0;
            end else begin
                if (w_frame_done && (r_frames != 16'hFFFF)) begin
                    r_frames <= r_frames + 16'd1;
                end
                if (w_state_nx == S_IDLE) begin
                    r_stop_pend <= 1'b0;
                end else if (bus.stop_in) begin
                    r_stop_pend <= 1'b1;
                end
            end
        end
    end

    assign bus.tx_d_out        = r_tx_d;
    assign bus.tx_en_out       = r_tx_en;
    assign bus.tx_err_out      = r_tx_err;
    assign bus.busy_out        = r_busy;
    assign bus.done_out        = r_done;
    assign bus.frames_sent_out = r_frames;
endmodule

// File: doc/eth_frame_gen.md
# eth_frame_gen

Parametrised GMII frame generator for the Ethernet subsystem, in the `eth_clk` domain ahead of the MAC transmit pins or the `eth_mac` receive port in loopback. It plays a frame from an internal byte buffer with preamble/SFD and optional minimum-length padding. It computes and appends the IEEE 802.3 FCS, enforces the inter-frame gap, and repeats for N frames or continuously. It can inject FCS or symbol errors.

## Interface
- `MEM_DEPTH`, 2048: frame buffer size in bytes; power of two.
- `ADDR_W`, 11: log2(`MEM_DEPTH`).
- `PRE_BYTES`, 7: number of 0x55 preamble bytes.
- `IFG_BYTES`, 12: idle cycles after each frame.
- `MIN_LEN`, 60: padded length (data+pad, excluding FCS).

- `clk` in 1: byte clock, 125 MHz; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `wr_en_in` in 1: buffer write strobe.
- `wr_addr_in` in `ADDR_W`: buffer write address.
- `wr_data_in` in 8: buffer write byte.
- `start_in` in 1: begin a run; sampled in IDLE only.
- `stop_in` in 1: end run after current frame.
- `len_in` in `ADDR_W`+1: frame bytes read from buffer, addresses 0..len-1.
- `count_in` in 16: frames per run; 0 = continuous.
- `mode_in` in 2: 00 normal, 01 raw (no pad, no FCS), 10 bad FCS, 11 error symbol.
- `pad_en_in` in 1: pad with 0x00 up to `MIN_LEN`.
- `err_idx_in` in `ADDR_W`: data byte index flagged in mode 11.
- `tx_d_out` out 8: GMII data.
- `tx_en_out` out 1: GMII enable.
- `tx_err_out` out 1: GMII error.
- `busy_out` out 1: run in progress.
- `done_out` out 1: one-cycle pulse at end of run.
- `frames_sent_out` out 16: completed frames this run; saturates at 0xFFFF.

## Operation
- Buffer: simple dual-port RAM with 1-cycle read latency. Writes are accepted at any time. Bytes read after a write return the new value. Reset does not clear the RAM.
- `len_in`, `count_in`, `mode_in`, `pad_en_in` and `err_idx_in` are latched on an accepted start and held for the whole run.
- A start is accepted only in IDLE with `len_in` != 0. Start with `len_in` = 0 is ignored, and `done_out` does not pulse.
- Latched len > `MEM_DEPTH` is clamped to `MEM_DEPTH`.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
  - IDLE -> PRE on accepted start.
  - PRE (`PRE_BYTES` cycles, 0x55) -> SFD (1 cycle, 0xD5) -> DATA (len cycles).
  - DATA -> PAD if pad enabled, mode != 01 and len < `MIN_LEN`. Otherwise DATA -> FCS, or DATA -> IFG in mode 01.
  - PAD (`MIN_LEN` - len cycles, 0x00) -> FCS (4 cycles) -> IFG (`IFG_BYTES` cycles, `tx_en_out`=0, `tx_d_out`=0).
  - IFG -> PRE for the next frame. IFG -> IDLE when count is reached (count != 0) or stop is pending.
- Buffer read address 0 is issued in the last PRE cycle so byte 0 is present in SFD+1.
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, over DATA and PAD bytes. FCS = ~crc, sent LSB byte first.
  - Mode 10: the last FCS byte is XOR 0x01.
  - Mode 11: `tx_err_out`=1 only during DATA byte `err_idx_in`. If the index is ≥ len, no error is asserted.
- `frames_sent_out` increments on the last FCS byte, or the last DATA byte in mode 01. It is cleared on accepted start.
- `stop_in` is sampled every cycle while busy and latched as pending. The current frame and its IFG always complete, with no truncation. A stop in the final IFG cycle still counts.
- `done_out` pulses in the first IDLE cycle after the run. `busy_out`=1 from PRE through the final IFG.

## Timing
- Reset values: `tx_d_out`=0, `tx_en_out`=0, `tx_err_out`=0, `busy_out`=0, `done_out`=0, `frames_sent_out`=0, state IDLE, stop pending cleared.
- Reset mid-frame: outputs are idle on the next cycle.
- All outputs are registered.
- First 0x55 appears one cycle after the start is sampled.
- Frame period, start of one preamble to the next: `PRE_BYTES`+1 + L + F + `IFG_BYTES` cycles.
  - L = max(len, `MIN_LEN`) when padding applies, else len.
  - F = 4, or 0 in mode 01.
- `tx_en_out` is continuous from the first preamble byte to the last FCS byte, with no gaps.
- A start asserted while busy is ignored. A start in the `done_out` cycle is accepted.

## Test plan
- Check vector: buffer "123456789" (0x31..0x39), len=9, pad off, mode 00, count 1 -> 55×7, D5, 31..39, then 26 39 F4 CB. Then 12 idle cycles, `done_out` pulse, `frames_sent_out`=1.
- Padding: same buffer, pad on, count 3 -> each frame has 60 data+pad bytes, the CRC over data+FCS gives residue 0xDEBB20E3, and frames start 84 cycles apart. Afterwards `frames_sent_out`=3.
- Raw replay: load an 86-byte frame that already contains its FCS, mode 01 -> 86 bytes are sent verbatim after SFD with no appended bytes. Checking in `eth_mac` loopback reports a good CRC.
- Error modes:
  - Mode 10 on the check vector -> last FCS byte is 0xCA.
  - Mode 11 with `err_idx_in`=4 -> `tx_err_out` is high only with byte 0x35.
- Continuous plus stop: count 0, `stop_in` pulsed mid-way through frame 2 -> frame 2 and its IFG complete, then IDLE. `frames_sent_out`=2 with a single `done_out`.
- Reset and corner cases:
  - `rst` low during DATA -> outputs are 0 the next cycle.
  - After reset, a start with `len_in`=0 is ignored.
  - A start while busy is ignored.
  - Buffer contents survive reset.
